// File: rtl/image_window_scaler_if.sv
// Memory-fetch and VGA-pin bundle of the image window scaler.
// mem_addr is sampled by the memory when mem_en is high; mem_data answers MEM_LAT enabled ticks later.
interface image_window_scaler_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [11:0]       mem_data;
    logic              hsync;
    logic              vsync;
    logic              video_on;
    logic              frame_start;
    logic [11:0]       rgb;

    modport master (
        output mem_addr, mem_en, hsync, vsync, video_on, frame_start, rgb,
        input  mem_data
    );

    modport slave (
        input  mem_addr, mem_en, hsync, vsync, video_on, frame_start, rgb,
        output mem_data
    );
endinterface

// File: rtl/image_window_scaler.sv
// VGA timing generator that places an IMG_W x IMG_H image at a runtime position,
// with optional 2^SCALE_LOG2 upscale, fetching pixels from a synchronous memory.
module image_window_scaler #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int          IMG_W      = 300,
    parameter int          IMG_H      = 200,
    parameter int          SCALE_LOG2 = 0,
    parameter int          ADDR_W     = 16,
    parameter int          MEM_LAT    = 1,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    image_window_scaler_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int S       = 1 << SCALE_LOG2;
    localparam int WIN_W   = IMG_W * S;
    localparam int WIN_H   = IMG_H * S;
    localparam int CW      = 12;
    localparam int SW      = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;

    localparam logic [CW-1:0]     H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]     V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [9:0]        POS_X0    = 10'((H_ACTIVE - WIN_W) / 2);
    localparam logic [9:0]        POS_Y0    = 10'((V_ACTIVE - WIN_H) / 2);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [SW-1:0]     SUB_LAST  = SW'(S - 1);

    // Flag vector bit positions carried down the pipeline.
    localparam int F_HS  = 0;
    localparam int F_VS  = 1;
    localparam int F_VON = 2;
    localparam int F_WIN = 3;
    localparam int F_FS  = 4;

    logic [CW-1:0]     h;
    logic [CW-1:0]     v;
    logic [9:0]        px;
    logic [9:0]        py;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] addr;
    logic [SW-1:0]     col_sub;
    logic [SW-1:0]     row_sub;
    logic              win_prev;
    logic [4:0]        dly [MEM_LAT+1];

    logic h_wrap, frame_end, active, in_win, hs_on, vs_on, fs_now;

    always_comb begin
        h_wrap    = (h == H_LAST);
        frame_end = h_wrap && (v == V_LAST);
        active    = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
        in_win    = active
                    && (h >= CW'(px)) && (h < CW'(px) + CW'(WIN_W))
                    && (v >= CW'(py)) && (v < CW'(py) + CW'(WIN_H));
        hs_on     = (h >= CW'(H_ACTIVE + H_FP)) && (h < CW'(H_ACTIVE + H_FP + H_SYNC));
        vs_on     = (v >= CW'(V_ACTIVE + V_FP)) && (v < CW'(V_ACTIVE + V_FP + V_SYNC));
        fs_now    = (h == '0) && (v == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h        <= '0;
            v        <= '0;
            px       <= POS_X0;
            py       <= POS_Y0;
            row_base <= '0;
            addr     <= '0;
            col_sub  <= '0;
            row_sub  <= '0;
            win_prev <= 1'b0;
        end else if (pix_ce) begin
            h        <= h_wrap ? '0 : h + CW'(1);
            if (h_wrap) v <= (v == V_LAST) ? '0 : v + CW'(1);
            win_prev <= in_win;

            if (in_win && !win_prev) begin
                addr    <= row_base;
                col_sub <= '0;
            end else if (in_win) begin
                // Each source pixel is repeated S times across the line.
                if (col_sub == SUB_LAST) begin
                    addr    <= addr + ADDR_W'(1);
                    col_sub <= '0;
                end else begin
                    col_sub <= col_sub + SW'(1);
                end
            end else if (win_prev) begin
                if (row_sub == SUB_LAST) begin
                    row_base <= row_base + ROW_STEP;
                    row_sub  <= '0;
                end else begin
                    row_sub  <= row_sub + SW'(1);
                end
            end

            // New position only ever applies from the next frame's first pixel.
            if (frame_end) begin
                px       <= pos_x;
                py       <= pos_y;
                row_base <= '0;
                row_sub  <= '0;
            end
        end
    end

    assign vga.mem_addr = addr;
    assign vga.mem_en   = pix_ce & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= MEM_LAT; i++) dly[i] <= '0;
            vga.hsync       <= ~SYNC_POL;
            vga.vsync       <= ~SYNC_POL;
            vga.video_on    <= 1'b0;
            vga.frame_start <= 1'b0;
            vga.rgb         <= '0;
        end else if (pix_ce) begin
            dly[0] <= {fs_now, in_win, active, vs_on, hs_on};
            for (int i = 1; i <= MEM_LAT; i++) dly[i] <= dly[i-1];
            vga.hsync       <= dly[MEM_LAT][F_HS] ? SYNC_POL : ~SYNC_POL;
            vga.vsync       <= dly[MEM_LAT][F_VS] ? SYNC_POL : ~SYNC_POL;
            vga.video_on    <= dly[MEM_LAT][F_VON];
            vga.frame_start <= dly[MEM_LAT][F_FS];
            vga.rgb         <= dly[MEM_LAT][F_VON]
                               ? (dly[MEM_LAT][F_WIN] ? vga.mem_data : BORDER_RGB)
                               : 12'h000;
        end
    end
endmodule
